// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, shift kinds and FSM states for the execute unit.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_PASS = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_e;
    typedef enum logic {IDLE, SHIFT} state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction

    function automatic shift_kind_e shift_kind(input logic [3:0] op);
        return op == ALU_SRA ? SH_RA : op == ALU_SRL ? SH_RL : SH_LL;
    endfunction
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: iterative one-bit-per-cycle shifter with down-counter.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     step,
    input  logic [1:0]               kind,
    input  logic [XLEN-1:0]          value,
    input  logic [$clog2(XLEN)-1:0]  amount,
    output logic [XLEN-1:0]          shifted,
    output logic                     last
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] data;
    logic [SW-1:0]   cnt;
    logic [1:0]      kind_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            cnt    <= '0;
            kind_q <= SH_LL;
        end else if (load) begin
            data   <= value;
            cnt    <= amount;
            kind_q <= kind;
        end else if (step && cnt != '0) begin
            data <= shifted;
            cnt  <= cnt - 1'b1;
        end
    end

    // shifted is the value after the step taken this cycle
    assign shifted = kind_q == SH_RA ? {data[XLEN-1], data[XLEN-1:1]} :
                     kind_q == SH_RL ? {1'b0, data[XLEN-1:1]} :
                                       {data[XLEN-2:0], 1'b0};
    assign last = cnt == SW'(1);
endmodule

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU with single-cycle ops and iterative shifts.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SW = $clog2(XLEN);

    state_e          state;
    logic            accept;
    logic            long_shift;
    logic            sh_last;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sh_next;

    assign in_ready   = state == IDLE && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign long_shift = is_shift_op(alu_op) && op_b[SW-1:0] != '0;

    // zero-amount shifts complete like ordinary ops and return op_a
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            default:  alu_res = op_b;
        endcase
    end

    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && long_shift),
        .step    (state == SHIFT),
        .kind    (shift_kind(alu_op)),
        .value   (op_a),
        .amount  (op_b[SW-1:0]),
        .shifted (sh_next),
        .last    (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && long_shift) begin
                        state     <= SHIFT;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        result    <= alu_res;
                        zero      <= alu_res == '0;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        state     <= IDLE;
                        result    <= sh_next;
                        zero      <= sh_next == '0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector self-checking bench for alu_exec.
module tb_alu_exec;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    int          tests = 0;
    int          fails = 0;

    vec_t vecs [NV] = '{
        '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_ADD,  32'h00000002, 32'h00000003, 32'h00000005},
        '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000},
        '{ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE},
        '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0},
        '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0},
        '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
        '{ALU_PASS, 32'hDEADBEEF, 32'hCAFEBABE, 32'hCAFEBABE},
        '{ALU_SLT,  32'hFFFFFFFE, 32'h00000001, 32'h00000001},
        '{ALU_SLTU, 32'hFFFFFFFE, 32'h00000001, 32'h00000000},
        '{ALU_SLT,  32'h00000001, 32'hFFFFFFFE, 32'h00000000},
        '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFE, 32'h00000001},
        '{4'hF,     32'h00000000, 32'h00001234, 32'h00001234},
        '{4'hB,     32'h00000005, 32'h00000000, 32'h00000000},
        '{ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001},
        '{ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000}
    };

    always #5 clk = ~clk;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
    endtask

    // unrelated ADD held on in_valid while the shift runs must never be captured
    task automatic run_shift(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        int n;
        int lat;
        n = int'(b[4:0]);
        drive(op, a, b);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("shift_in_ready_low", {31'b0, in_ready}, 32'h0);
            drive(ALU_ADD, 32'h7, 32'h7);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("shift_latency", lat, n + 1);
        check("shift_result", result, exp);
        check("shift_zero", {31'b0, zero}, {31'b0, exp == 32'h0});
        @(negedge clk);
        check("shift_drain", {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

        // back-to-back stream of single-cycle ops
        drive(vecs[0].op, vecs[0].a, vecs[0].b);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp == 32'h0});
            if (i + 1 < NV) drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream_drain", {31'b0, out_valid}, 32'h0);

        // backpressure holds the result
        out_ready = 1'b0;
        drive(ALU_SUB, 32'h5, 32'h5);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", {31'b0, out_valid}, 32'h1);
            check("hold_result", result, 32'h0);
            check("hold_zero", {31'b0, zero}, 32'h1);
            check("hold_in_ready", {31'b0, in_ready}, 32'h0);
            drive(ALU_ADD, 32'h2, 32'h3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", {31'b0, out_valid}, 32'h1);
        check("b2b_result", result, 32'h5);
        check("b2b_zero", {31'b0, zero}, 32'h0);
        @(negedge clk);
        check("b2b_drain", {31'b0, out_valid}, 32'h0);

        run_shift(ALU_SRA, 32'h80000000, 32'h4,  32'hF8000000);
        run_shift(ALU_SRL, 32'h80000000, 32'h1,  32'h40000000);
        run_shift(ALU_SLL, 32'h00000003, 32'h2,  32'h0000000C);
        run_shift(ALU_SRA, 32'h7FFFFFFF, 32'h1F, 32'h00000000);
        run_shift(ALU_SLL, 32'h12345678, 32'h20, 32'h12345678);
        run_shift(ALU_SRL, 32'hF0000000, 32'h24, 32'h0F000000);

        // reset in the middle of a long shift
        drive(ALU_SLL, 32'h1, 32'd31);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'h1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
